// File: rtl/count_disp_scan.sv
// Display stage for the 4-bit counter: keeps a 4-deep history of sampled counts
// and scans it onto a 4-digit common-anode seven-segment display in hex.
module count_disp_scan #(
    parameter int SCAN_DIV = 50000,
    parameter int DIV_W    = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] din,
    input  logic       sample,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic [3:0] hist_valid
);

    logic [3:0]       h_reg [4];
    logic [3:0]       valid_reg;
    logic [DIV_W-1:0] presc_reg;
    logic [1:0]       idx_reg;
    logic [6:0]       seg_reg;
    logic             dp_reg;
    logic [3:0]       an_reg;
    logic             wrap;

    // Active-low abcdefg patterns, seg[6] = a.
    function automatic logic [6:0] hex_pattern(input logic [3:0] v);
        case (v)
            4'h0:    return 7'b0000001;
            4'h1:    return 7'b1001111;
            4'h2:    return 7'b0010010;
            4'h3:    return 7'b0000110;
            4'h4:    return 7'b1001100;
            4'h5:    return 7'b0100100;
            4'h6:    return 7'b0100000;
            4'h7:    return 7'b0001111;
            4'h8:    return 7'b0000000;
            4'h9:    return 7'b0000100;
            4'hA:    return 7'b0001000;
            4'hB:    return 7'b1100000;
            4'hC:    return 7'b0110001;
            4'hD:    return 7'b1000010;
            4'hE:    return 7'b0110000;
            default: return 7'b0111000;
        endcase
    endfunction

    assign wrap = (presc_reg == DIV_W'(SCAN_DIV - 1));

    // History shift register: slot 0 takes din, every other slot takes its neighbour.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_hist
            always_ff @(posedge clk) begin
                if (reset) begin
                    h_reg[gi] <= 4'h0;
                end else if (sample) begin
                    if (gi == 0) h_reg[gi] <= din;
                    else         h_reg[gi] <= h_reg[(gi == 0) ? 0 : gi - 1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_reg <= 4'b0000;
            presc_reg <= '0;
            idx_reg   <= 2'd0;
            an_reg    <= 4'b1111;
            seg_reg   <= 7'b1111111;
            dp_reg    <= 1'b1;
        end else begin
            if (sample) valid_reg <= {valid_reg[2:0], 1'b1};
            if (wrap) begin
                presc_reg <= '0;
                idx_reg   <= idx_reg + 2'd1;
            end else begin
                presc_reg <= presc_reg + DIV_W'(1);
            end
            // Outputs use the pre-edge idx/history so a digit switch lands one cycle late.
            an_reg  <= ~(4'b0001 << idx_reg);
            seg_reg <= valid_reg[idx_reg] ? hex_pattern(h_reg[idx_reg]) : 7'b1111111;
            dp_reg  <= ~((idx_reg == 2'd0) && valid_reg[0]);
        end
    end

    assign seg        = seg_reg;
    assign dp         = dp_reg;
    assign an         = an_reg;
    assign hist_valid = valid_reg;

endmodule

// File: tb/tb_count_disp_scan.sv
// Bench for count_disp_scan: behavioural model feeds an expected-output queue,
// plus a hex-pattern vector table and directed multi-cycle corner cases.
module tb_count_disp_scan;

    logic       clk;
    logic       reset;
    logic [3:0] din;
    logic       sample;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic [3:0] hist_valid;

    count_disp_scan #(.SCAN_DIV(4), .DIV_W(16)) dut (
        .clk(clk), .reset(reset), .din(din), .sample(sample),
        .seg(seg), .dp(dp), .an(an), .hist_valid(hist_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] din;
        logic [6:0] seg;
    } hex_vec_t;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic [3:0] hv;
    } exp_t;

    hex_vec_t tbl [16];
    exp_t     exp_q [$];
    int       checks = 0;
    int       errors = 0;

    // Reference model state
    logic [3:0] m_h [4];
    logic [3:0] m_hv;
    int         m_pre;
    int         m_idx;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic s, input logic [3:0] d);
        exp_t e;
        if (r) begin
            e.an = 4'b1111; e.seg = 7'b1111111; e.dp = 1'b1; e.hv = 4'b0000;
            for (int i = 0; i < 4; i++) m_h[i] = 4'h0;
            m_hv = 4'b0000; m_pre = 0; m_idx = 0;
        end else begin
            e.an  = 4'b1111;
            e.an[m_idx] = 1'b0;
            e.seg = m_hv[m_idx] ? tbl[m_h[m_idx]].seg : 7'b1111111;
            e.dp  = (m_idx == 0 && m_hv[0]) ? 1'b0 : 1'b1;
            if (s) begin
                m_h[3] = m_h[2]; m_h[2] = m_h[1]; m_h[1] = m_h[0]; m_h[0] = d;
                m_hv = {m_hv[2:0], 1'b1};
            end
            e.hv = m_hv;
            if (m_pre == 3) begin
                m_pre = 0;
                m_idx = (m_idx + 1) % 4;
            end else begin
                m_pre++;
            end
        end
        exp_q.push_back(e);
    endtask

    // One clock: drive at negedge, predict, compare 1 time unit after the edge.
    task automatic cyc(input logic r, input logic s, input logic [3:0] d);
        exp_t e;
        @(negedge clk);
        reset = r; sample = s; din = d;
        model_step(r, s, d);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL queue: empty scoreboard at %0t", $time);
        end else begin
            e = exp_q.pop_front();
            chk("an", {28'd0, an}, {28'd0, e.an});
            chk("seg", {25'd0, seg}, {25'd0, e.seg});
            chk("dp", {31'd0, dp}, {31'd0, e.dp});
            chk("hist_valid", {28'd0, hist_valid}, {28'd0, e.hv});
        end
        $display("cyc t=%0t reset=%b sample=%b din=%h -> an=%b seg=%b dp=%b hv=%b",
                 $time, r, s, d, an, seg, dp, hist_valid);
    endtask

    initial begin
        logic [3:0] exp_an;
        tbl[0]  = '{4'h0, 7'b0000001}; tbl[1]  = '{4'h1, 7'b1001111};
        tbl[2]  = '{4'h2, 7'b0010010}; tbl[3]  = '{4'h3, 7'b0000110};
        tbl[4]  = '{4'h4, 7'b1001100}; tbl[5]  = '{4'h5, 7'b0100100};
        tbl[6]  = '{4'h6, 7'b0100000}; tbl[7]  = '{4'h7, 7'b0001111};
        tbl[8]  = '{4'h8, 7'b0000000}; tbl[9]  = '{4'h9, 7'b0000100};
        tbl[10] = '{4'hA, 7'b0001000}; tbl[11] = '{4'hB, 7'b1100000};
        tbl[12] = '{4'hC, 7'b0110001}; tbl[13] = '{4'hD, 7'b1000010};
        tbl[14] = '{4'hE, 7'b0110000}; tbl[15] = '{4'hF, 7'b0111000};

        reset = 1'b1; sample = 1'b0; din = 4'h0;

        // 1: reset 3 cycles, then an walks with blank digits
        repeat (3) cyc(1'b1, 1'b0, 4'h0);
        chk("rst_an", {28'd0, an}, 32'hF);
        chk("rst_seg", {25'd0, seg}, 32'h7F);
        for (int k = 1; k <= 17; k++) begin
            cyc(1'b0, 1'b0, 4'(k));
            exp_an = 4'b1111;
            exp_an[((k - 1) / 4) % 4] = 1'b0;
            chk("walk_an", {28'd0, an}, {28'd0, exp_an});
        end

        // 2: single sample of 5 at idx 0
        cyc(1'b1, 1'b0, 4'h0);
        cyc(1'b0, 1'b1, 4'h5);
        cyc(1'b0, 1'b0, 4'h0);
        chk("s2_seg", {25'd0, seg}, 32'b0100100);
        chk("s2_dp", {31'd0, dp}, 32'd0);
        chk("s2_hv", {28'd0, hist_valid}, 32'b0001);
        repeat (14) cyc(1'b0, 1'b0, 4'h0);

        // 3 + 4: four samples, a full scan, then a fifth sample dropping the oldest
        cyc(1'b1, 1'b0, 4'h0);
        cyc(1'b0, 1'b1, 4'h3);
        cyc(1'b0, 1'b1, 4'h7);
        cyc(1'b0, 1'b1, 4'hA);
        cyc(1'b0, 1'b1, 4'hF);
        chk("s3_hv", {28'd0, hist_valid}, 32'b1111);
        repeat (16) cyc(1'b0, 1'b0, 4'h0);
        cyc(1'b0, 1'b1, 4'h0);
        repeat (16) cyc(1'b0, 1'b0, 4'h0);

        // 6: reset with sample high mid-scan
        repeat (2) cyc(1'b0, 1'b0, 4'h0);
        cyc(1'b1, 1'b1, 4'h8);
        chk("s6_an", {28'd0, an}, 32'hF);
        chk("s6_seg", {25'd0, seg}, 32'h7F);
        cyc(1'b0, 1'b0, 4'h0);
        chk("s6_an2", {28'd0, an}, 32'hE);
        chk("s6_hv", {28'd0, hist_valid}, 32'd0);

        // 5: sample on the wrap edge from idx 0 to idx 1
        cyc(1'b0, 1'b1, 4'h2);
        cyc(1'b0, 1'b0, 4'h0);
        cyc(1'b0, 1'b0, 4'h0);
        cyc(1'b0, 1'b1, 4'h9);
        cyc(1'b0, 1'b0, 4'h0);
        chk("s5_an", {28'd0, an}, 32'b1101);
        chk("s5_seg", {25'd0, seg}, 32'b0010010);

        // Hex pattern table: capture each value at idx 0 and read digit 0
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 1'b0, 4'h0);
            cyc(1'b0, 1'b1, tbl[i].din);
            cyc(1'b0, 1'b0, ~tbl[i].din);
            chk("hex_seg", {25'd0, seg}, {25'd0, tbl[i].seg});
            chk("hex_an", {28'd0, an}, 32'b1110);
            chk("hex_dp", {31'd0, dp}, 32'd0);
        end

        // Random traffic, including din changing without sample and occasional reset
        for (int i = 0; i < 300; i++) begin
            cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0), 4'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
